// File: rtl/serial_pkg.sv
// Shared constants and state encoding for the serial frame path.
// Used by the transmitter and the matching receiver.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/bit_tick_counter.sv
// Counts clocks inside one serial bit period.
// bit_end marks the last clock of a bit; bit_last_next says the following
// clock will be a last clock, which lets the owner register a pulse aligned
// with it. The counter is held at zero while disabled.
module bit_tick_counter #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic bit_end,
  output logic bit_last_next
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next tick count: wrap at the last clock of a bit, clear while idle.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable)            cnt_d = '0;
    else if (cnt_q == LAST) cnt_d = '0;
    else                    cnt_d = cnt_q + 1'b1;
  end

  // Tick counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bit_end = enable && (cnt_q == LAST);

  // With one clock per bit every clock is a last clock.
  generate
    if (CLKS_PER_BIT == 1) begin : g_single
      assign bit_last_next = enable;
    end else begin : g_multi
      assign bit_last_next = enable && (cnt_q == CW'(CLKS_PER_BIT - 2));
    end
  endgenerate

endmodule

// File: rtl/serial_frame_transmitter.sv
// Parallel-to-serial frame transmitter: start bit, DATA_W bits LSB-first,
// optional even-parity bit, stop bit; each bit lasts CLKS_PER_BIT clocks.
// Optional feature macro: SERIAL_TX_PARITY_EN (adds the PARITY state).
// All outputs are registered from the next-state values so the line drops
// on the very edge that accepts a word.
module serial_frame_transmitter
  import serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_serial,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int BW = $clog2(DATA_W) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              serial_q, serial_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef SERIAL_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic bit_end;
  logic bit_last_next;

  bit_tick_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk          (clk),
    .rst          (rst),
    .enable       (state_q != IDLE),
    .bit_end      (bit_end),
    .bit_last_next(bit_last_next)
  );

  // Next state, shift register and bit counter.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
`ifdef SERIAL_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (tx_valid && ready_q) begin
          state_d   = START;
          shift_d   = tx_data;
          bit_cnt_d = '0;
`ifdef SERIAL_TX_PARITY_EN
          parity_d  = ^tx_data;
`endif
        end
      end
      START: if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP:   if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs derived from the state being entered.
  always_comb begin
    serial_d = LINE_IDLE;
    case (state_d)
      START:  serial_d = START_BIT;
      DATA:   serial_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
      PARITY: serial_d = parity_d;
`endif
      STOP:   serial_d = STOP_BIT;
      default: serial_d = LINE_IDLE;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    // Last clock of the stop bit: either staying in STOP with one tick left,
    // or entering a single-clock STOP.
    done_d  = (state_d == STOP) &&
              ((state_q == STOP) ? bit_last_next : (CLKS_PER_BIT == 1));
  end

  // State and output registers; reset forces the line high at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      serial_q  <= LINE_IDLE;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      serial_q  <= serial_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign tx_ready  = ready_q;
  assign tx_serial = serial_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;

endmodule

// File: tb/tb_serial_frame_transmitter.sv
// Scoreboard bench for serial_frame_transmitter: two instances,
// CLKS_PER_BIT=4 (u_dut0) and CLKS_PER_BIT=1 (u_dut1), DATA_W=8.
module tb_serial_frame_transmitter;

`ifdef SERIAL_TX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int FRAME0 = (8 + 2 + PBITS) * 4;
  localparam int FRAME1 = (8 + 2 + PBITS) * 1;

  typedef struct packed {
    logic ser;
    logic done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       valid0 = 1'b0, valid1 = 1'b0;
  logic       ready0, ser0, busy0, done0;
  logic       ready1, ser1, busy1, done1;

  exp_t q0[$];
  exp_t q1[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  serial_frame_transmitter #(.DATA_W(8), .CLKS_PER_BIT(4)) u_dut0 (
    .clk(clk), .rst(rst), .tx_data(data0), .tx_valid(valid0),
    .tx_ready(ready0), .tx_serial(ser0), .tx_busy(busy0), .tx_done(done0)
  );

  serial_frame_transmitter #(.DATA_W(8), .CLKS_PER_BIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .tx_data(data1), .tx_valid(valid1),
    .tx_ready(ready1), .tx_serial(ser1), .tx_busy(busy1), .tx_done(done1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected per-clock line levels for one frame, last clock flagged done.
  task automatic push_frame(input int which, input logic [7:0] d);
    logic bits[$];
    int   cpb;
    exp_t e;
    cpb = (which == 0) ? 4 : 1;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef SERIAL_TX_PARITY_EN
    bits.push_back(^d);
`endif
    bits.push_back(1'b1);
    for (int b = 0; b < bits.size(); b++)
      for (int c = 0; c < cpb; c++) begin
        e.ser  = bits[b];
        e.done = (b == bits.size() - 1) && (c == cpb - 1);
        if (which == 0) q0.push_back(e);
        else            q1.push_back(e);
      end
  endtask

  task automatic wait_done(input int which);
    bit seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = (which == 0) ? done0 : done1;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  // One-cycle valid pulse, then wait for the frame to finish.
  task automatic send(input int which, input logic [7:0] d);
    @(posedge clk); #1;
    push_frame(which, d);
    if (which == 0) begin data0 = d; valid0 = 1'b1; end
    else            begin data1 = d; valid1 = 1'b1; end
    @(posedge clk); #1;
    valid0 = 1'b0;
    valid1 = 1'b0;
    wait_done(which);
  endtask

  // Monitor for instance 0.
  initial begin
    exp_t e;
    int   len = 0;
    bit   prev_done = 0;
    forever begin
      @(negedge clk);
      if (prev_done) chk("gap0_busy", busy0, 0);
      prev_done = done0;
      if (busy0) begin
        if (q0.size() == 0) chk("unexpected_busy0", busy0, 0);
        else begin
          e = q0.pop_front();
          len++;
          chk("serial0", ser0, e.ser);
          chk("done0", done0, e.done);
          chk("ready_busy0", ready0, 0);
          if (e.done) begin
            chk("frame_len0", len, FRAME0);
            len = 0;
          end
        end
      end else begin
        len = 0;
        chk("idle_serial0", ser0, 1);
        chk("idle_ready0", ready0, 1);
        chk("idle_done0", done0, 0);
      end
    end
  end

  // Monitor for instance 1.
  initial begin
    exp_t e;
    int   len = 0;
    bit   prev_done = 0;
    forever begin
      @(negedge clk);
      if (prev_done) chk("gap1_busy", busy1, 0);
      prev_done = done1;
      if (busy1) begin
        if (q1.size() == 0) chk("unexpected_busy1", busy1, 0);
        else begin
          e = q1.pop_front();
          len++;
          chk("serial1", ser1, e.ser);
          chk("done1", done1, e.done);
          if (e.done) begin
            chk("frame_len1", len, FRAME1);
            len = 0;
          end
        end
      end else begin
        len = 0;
        chk("idle_serial1", ser1, 1);
        chk("idle_done1", done1, 0);
      end
    end
  end

  // Stimulus.
  initial begin
    // Reset held 30 ns with a valid word offered: nothing may be accepted.
    #1 rst = 1'b1;
    valid0 = 1'b1;
    data0  = 8'hA5;
    #29;
    chk("rst_serial", ser0, 1);
    chk("rst_ready", ready0, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    valid0 = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    // Single frames, including the parity-sensitive patterns.
    send(0, 8'hA5);
    send(0, 8'h07);

    // Hold-off: valid stays high; data changes while busy are ignored.
    @(posedge clk); #1;
    push_frame(0, 8'h3C);
    data0 = 8'h3C; valid0 = 1'b1;
    @(posedge clk); #1;
    data0 = 8'h55;
    repeat (10) @(posedge clk);
    #1;
    push_frame(0, 8'h81);
    data0 = 8'h81;
    wait_done(0);
    @(posedge clk);
    @(posedge clk); #1;   // second word accepted at this edge
    valid0 = 1'b0;
    data0  = 8'h00;
    wait_done(0);

    // Reset during data bit 3 of an all-ones frame.
    @(posedge clk); #1;
    push_frame(0, 8'hFF);
    data0 = 8'hFF; valid0 = 1'b1;
    @(posedge clk); #1;
    valid0 = 1'b0;
    repeat (17) @(posedge clk);
    #2;
    chk("pre_rst_busy", busy0, 1);
    chk("pre_rst_serial", ser0, 1);
    rst = 1'b1;
    q0.delete();
    #1;
    chk("midrst_serial", ser0, 1);
    chk("midrst_busy", busy0, 0);
    chk("midrst_ready", ready0, 1);
    chk("midrst_done", done0, 0);
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;
    repeat (60) @(posedge clk);

    // One clock per bit.
    send(1, 8'h00);
    send(1, 8'h5A);

    // Drain both scoreboards.
    for (int i = 0; i < 500 && (q0.size() != 0 || q1.size() != 0); i++)
      @(posedge clk);
    repeat (3) @(posedge clk);
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
